// File: rtl/instruction_decode.sv
// RV64I decode stage: register-file read, control/immediate decode and the ID/EX
// pipeline register, with load-use bubble insertion and branch flush.
module instruction_decode (
    input  logic        clk,
    input  logic        rst,
    input  logic        input_valid,
    input  logic [31:0] instruction,
    input  logic [63:0] instruction_pc,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    input  logic [63:0] rs1_data,
    input  logic [63:0] rs2_data,
    input  logic        stall_in,
    output logic        stall_out,
    input  logic        branch_reset_in,
    output logic        branch_reset_out,
    output logic        output_valid,
    output logic [63:0] out_pc,
    output logic [4:0]  rd,
    output logic [63:0] rs1_val,
    output logic [63:0] rs2_val,
    output logic [63:0] imm,
    output logic [3:0]  alu_op,
    output logic        alu_src_imm,
    output logic        is_word,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  mem_size,
    output logic        mem_unsigned,
    output logic        reg_write,
    output logic        is_branch,
    output logic        is_jal,
    output logic        is_jalr,
    output logic        is_auipc,
    output logic [2:0]  branch_funct3,
    output logic        illegal
);

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
        ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
        ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [4:0]  rd;
        logic [63:0] rs1_val;
        logic [63:0] rs2_val;
        logic [63:0] imm;
        alu_op_e     alu_op;
        logic        alu_src_imm;
        logic        is_word;
        logic        mem_read;
        logic        mem_write;
        logic [1:0]  mem_size;
        logic        mem_unsigned;
        logic        reg_write;
        logic        is_branch;
        logic        is_jal;
        logic        is_jalr;
        logic        is_auipc;
        logic [2:0]  branch_funct3;
        logic        illegal;
    } bundle_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OPIMMW = 7'b0011011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPW    = 7'b0111011;

    function automatic alu_op_e alu_sel(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        op = ALU_ADD;
        case (f3)
            3'd0: op = alt ? ALU_SUB : ALU_ADD;
            3'd1: op = ALU_SLL;
            3'd2: op = ALU_SLT;
            3'd3: op = ALU_SLTU;
            3'd4: op = ALU_XOR;
            3'd5: op = alt ? ALU_SRA : ALU_SRL;
            3'd6: op = ALU_OR;
            3'd7: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        bad, rs1_used, rs2_used, load_use;
    bundle_t     dec, bundle_d, bundle_q;
    logic        branch_reset_d, branch_reset_q;

    assign opcode   = instruction[6:0];
    assign funct3   = instruction[14:12];
    assign rs1_addr = instruction[19:15];
    assign rs2_addr = instruction[24:20];

    assign imm_i = {{52{instruction[31]}}, instruction[31:20]};
    assign imm_s = {{52{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b = {{51{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
    assign imm_u = {{32{instruction[31]}}, instruction[31:12], 12'b0};
    assign imm_j = {{43{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};

    always_comb begin
        dec         = '0;
        bad         = 1'b0;
        rs1_used    = 1'b1;
        rs2_used    = 1'b0;
        dec.pc      = instruction_pc;
        dec.rd      = instruction[11:7];
        dec.rs1_val = (rs1_addr == 5'd0) ? 64'd0 : rs1_data;
        dec.rs2_val = (rs2_addr == 5'd0) ? 64'd0 : rs2_data;
        dec.alu_op  = ALU_ADD;
        case (opcode)
            OPC_LUI: begin
                dec.imm = imm_u; dec.alu_op = ALU_PASSB;
                dec.alu_src_imm = 1'b1; dec.reg_write = 1'b1; rs1_used = 1'b0;
            end
            OPC_AUIPC: begin
                dec.imm = imm_u; dec.is_auipc = 1'b1; dec.reg_write = 1'b1; rs1_used = 1'b0;
            end
            OPC_JAL: begin
                dec.imm = imm_j; dec.is_jal = 1'b1; dec.reg_write = 1'b1; rs1_used = 1'b0;
            end
            OPC_JALR: begin
                dec.imm = imm_i; dec.is_jalr = 1'b1; dec.reg_write = 1'b1;
                bad = (funct3 != 3'd0);
            end
            OPC_BRANCH: begin
                dec.imm = imm_b; dec.is_branch = 1'b1; dec.alu_op = ALU_SUB;
                dec.branch_funct3 = funct3; rs2_used = 1'b1;
                bad = (funct3 == 3'd2) || (funct3 == 3'd3);
            end
            OPC_LOAD: begin
                dec.imm = imm_i; dec.mem_read = 1'b1; dec.reg_write = 1'b1;
                dec.mem_size = funct3[1:0]; dec.mem_unsigned = funct3[2];
                bad = (funct3 == 3'd7);
            end
            OPC_STORE: begin
                dec.imm = imm_s; dec.mem_write = 1'b1; dec.mem_size = funct3[1:0];
                rs2_used = 1'b1; bad = funct3[2];
            end
            OPC_OPIMM, OPC_OPIMMW: begin
                dec.imm = imm_i; dec.alu_src_imm = 1'b1; dec.reg_write = 1'b1;
                dec.is_word = (opcode == OPC_OPIMMW);
                dec.alu_op = alu_sel(funct3, instruction[30] && (funct3 == 3'd5));
                // Shamt is 6 bits wide for the 64-bit form, so bit 25 is part of it there.
                if (dec.is_word) begin
                    bad = !(funct3 inside {3'd0, 3'd1, 3'd5})
                        || ((funct3 == 3'd1) && (instruction[31:25] != 7'b0000000))
                        || ((funct3 == 3'd5) && (instruction[31:25] != 7'b0000000)
                                             && (instruction[31:25] != 7'b0100000));
                end else begin
                    bad = ((funct3 == 3'd1) && (instruction[31:26] != 6'b000000))
                        || ((funct3 == 3'd5) && (instruction[31:26] != 6'b000000)
                                             && (instruction[31:26] != 6'b010000));
                end
            end
            OPC_OP, OPC_OPW: begin
                dec.reg_write = 1'b1; rs2_used = 1'b1;
                dec.is_word = (opcode == OPC_OPW);
                dec.alu_op = alu_sel(funct3, instruction[30]);
                bad = !((instruction[31:25] == 7'b0000000)
                     || ((instruction[31:25] == 7'b0100000) && (funct3 inside {3'd0, 3'd5})))
                   || (dec.is_word && !(funct3 inside {3'd0, 3'd1, 3'd5}));
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            dec.reg_write = 1'b0;
            dec.mem_read  = 1'b0;
            dec.mem_write = 1'b0;
        end
        if (dec.rd == 5'd0) dec.reg_write = 1'b0;
        dec.illegal = bad;
    end

    assign load_use = bundle_q.valid && bundle_q.mem_read && (bundle_q.rd != 5'd0) && input_valid
                   && ((rs1_used && (bundle_q.rd == rs1_addr)) || (rs2_used && (bundle_q.rd == rs2_addr)));
    assign stall_out = stall_in | load_use;

    always_comb begin
        bundle_d       = bundle_q;
        branch_reset_d = branch_reset_in;
        if (branch_reset_in) begin
            bundle_d.valid = 1'b0;
        end else if (stall_in) begin
            bundle_d = bundle_q;
        end else if (load_use) begin
            bundle_d.valid = 1'b0;
        end else begin
            bundle_d       = dec;
            bundle_d.valid = input_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bundle_q       <= '0;
            branch_reset_q <= 1'b0;
        end else begin
            bundle_q       <= bundle_d;
            branch_reset_q <= branch_reset_d;
        end
    end

    assign branch_reset_out = branch_reset_q;
    assign output_valid     = bundle_q.valid;
    assign out_pc           = bundle_q.pc;
    assign rd               = bundle_q.rd;
    assign rs1_val          = bundle_q.rs1_val;
    assign rs2_val          = bundle_q.rs2_val;
    assign imm              = bundle_q.imm;
    assign alu_op           = bundle_q.alu_op;
    assign alu_src_imm      = bundle_q.alu_src_imm;
    assign is_word          = bundle_q.is_word;
    assign mem_read         = bundle_q.mem_read;
    assign mem_write        = bundle_q.mem_write;
    assign mem_size         = bundle_q.mem_size;
    assign mem_unsigned     = bundle_q.mem_unsigned;
    assign reg_write        = bundle_q.reg_write;
    assign is_branch        = bundle_q.is_branch;
    assign is_jal           = bundle_q.is_jal;
    assign is_jalr          = bundle_q.is_jalr;
    assign is_auipc         = bundle_q.is_auipc;
    assign branch_funct3    = bundle_q.branch_funct3;
    assign illegal          = bundle_q.illegal;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode: decode fields, hazards, stalls, flush, reset.
module tb_instruction_decode;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        input_valid = 1'b0;
    logic [31:0] instruction = 32'd0;
    logic [63:0] instruction_pc = 64'd0;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [63:0] rs1_data = 64'd0, rs2_data = 64'd0;
    logic        stall_in = 1'b0, stall_out;
    logic        branch_reset_in = 1'b0, branch_reset_out;
    logic        output_valid;
    logic [63:0] out_pc, rs1_val, rs2_val, imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        alu_src_imm, is_word, mem_read, mem_write, mem_unsigned, reg_write;
    logic [1:0]  mem_size;
    logic        is_branch, is_jal, is_jalr, is_auipc, illegal;
    logic [2:0]  branch_funct3;

    int tests = 0;
    int fails = 0;

    localparam logic [31:0] I_ADDI_M1 = 32'hFFF00293;
    localparam logic [31:0] I_LD      = 32'h0080B303;
    localparam logic [31:0] I_ADD     = 32'h002303B3;
    localparam logic [31:0] I_BEQ     = 32'hFE000EE3;
    localparam logic [31:0] I_SD      = 32'h0020B823;
    localparam logic [31:0] I_LUI     = 32'h80000237;
    localparam logic [31:0] I_SRAI    = 32'h43F2D293;
    localparam logic [31:0] I_ADDI5   = 32'h00500093;
    localparam logic [31:0] I_ORI     = 32'h00306113;
    localparam logic [31:0] I_BADOPC  = 32'h00000FFF;
    localparam logic [31:0] I_MUL     = 32'h022081B3;

    instruction_decode dut (
        .clk(clk), .rst(rst), .input_valid(input_valid), .instruction(instruction),
        .instruction_pc(instruction_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .stall_in(stall_in), .stall_out(stall_out),
        .branch_reset_in(branch_reset_in), .branch_reset_out(branch_reset_out),
        .output_valid(output_valid), .out_pc(out_pc), .rd(rd), .rs1_val(rs1_val),
        .rs2_val(rs2_val), .imm(imm), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
        .is_word(is_word), .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned), .reg_write(reg_write), .is_branch(is_branch),
        .is_jal(is_jal), .is_jalr(is_jalr), .is_auipc(is_auipc),
        .branch_funct3(branch_funct3), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; input_valid = 1'b1; instruction = I_ADDI_M1; instruction_pc = 64'h10;
        tick; tick;
        tests++;
        if ({output_valid, reg_write, illegal, branch_reset_out, rd, imm, out_pc} !== '0) begin
            fails++;
            $display("FAIL reset_state: valid=%b rw=%b rd=%0d imm=%h pc=%h, need all 0",
                     output_valid, reg_write, rd, imm, out_pc);
        end
        rst = 1'b0; input_valid = 1'b0;
        tick;
    endtask

    task automatic test_addi;
        instruction = I_ADDI_M1; instruction_pc = 64'h1000; rs1_data = 64'h1234; input_valid = 1'b1;
        #1;
        tests++;
        if ({rs1_addr, rs2_addr} !== {5'd0, 5'd31}) begin
            fails++; $display("FAIL addi_rs_addr: got %0d/%0d need 0/31", rs1_addr, rs2_addr);
        end
        tick;
        tests++;
        if ({output_valid, rd, alu_op, alu_src_imm, reg_write} !== {1'b1, 5'd5, 4'd0, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL addi_ctrl: v=%b rd=%0d op=%0d src=%b rw=%b need 1/5/0/1/1",
                     output_valid, rd, alu_op, alu_src_imm, reg_write);
        end
        tests++;
        if ({imm, rs1_val, out_pc} !== {64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'h1000}) begin
            fails++;
            $display("FAIL addi_data: imm=%h rs1=%h pc=%h need ffffffffffffffff/0/1000", imm, rs1_val, out_pc);
        end
        input_valid = 1'b0;
    endtask

    task automatic test_load_use;
        instruction = I_LD; instruction_pc = 64'h2000; rs1_data = 64'h100; input_valid = 1'b1;
        tick;
        tests++;
        if ({output_valid, mem_read, mem_size, mem_unsigned, rd, imm, rs1_val, reg_write}
            !== {1'b1, 1'b1, 2'd3, 1'b0, 5'd6, 64'd8, 64'h100, 1'b1}) begin
            fails++;
            $display("FAIL ld_decode: v=%b mr=%b sz=%0d u=%b rd=%0d imm=%h rs1=%h rw=%b",
                     output_valid, mem_read, mem_size, mem_unsigned, rd, imm, rs1_val, reg_write);
        end
        instruction = I_ADD; instruction_pc = 64'h2004;
        rs1_data = 64'hAAAA_BBBB_CCCC_DDDD; rs2_data = 64'h55;
        #1;
        tests++;
        if (stall_out !== 1'b1) begin fails++; $display("FAIL lu_stall: got %b need 1", stall_out); end
        tick;
        tests++;
        if (output_valid !== 1'b0) begin fails++; $display("FAIL lu_bubble: valid=%b need 0", output_valid); end
        tests++;
        if (stall_out !== 1'b0) begin fails++; $display("FAIL lu_stall_once: got %b need 0", stall_out); end
        tick;
        tests++;
        if ({output_valid, rd, rs1_val, rs2_val, alu_src_imm, alu_op, out_pc}
            !== {1'b1, 5'd7, 64'hAAAA_BBBB_CCCC_DDDD, 64'h55, 1'b0, 4'd0, 64'h2004}) begin
            fails++;
            $display("FAIL lu_add: v=%b rd=%0d rs1=%h rs2=%h src=%b op=%0d pc=%h",
                     output_valid, rd, rs1_val, rs2_val, alu_src_imm, alu_op, out_pc);
        end
        input_valid = 1'b0;
    endtask

    task automatic test_branch;
        instruction = I_BEQ; instruction_pc = 64'h3000; input_valid = 1'b1;
        tick;
        tests++;
        if ({output_valid, is_branch, branch_funct3, reg_write, alu_op, illegal, imm}
            !== {1'b1, 1'b1, 3'd0, 1'b0, 4'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC}) begin
            fails++;
            $display("FAIL beq: v=%b br=%b f3=%0d rw=%b op=%0d ill=%b imm=%h",
                     output_valid, is_branch, branch_funct3, reg_write, alu_op, illegal, imm);
        end
        input_valid = 1'b0;
    endtask

    task automatic test_back_to_back;
        input_valid = 1'b1; rs1_data = 64'h0; rs2_data = 64'h0;
        instruction = I_SD; instruction_pc = 64'h4000;
        tick;
        tests++;
        if ({output_valid, mem_write, mem_read, mem_size, reg_write, imm}
            !== {1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 64'd16}) begin
            fails++;
            $display("FAIL sd: v=%b mw=%b mr=%b sz=%0d rw=%b imm=%h",
                     output_valid, mem_write, mem_read, mem_size, reg_write, imm);
        end
        instruction = I_LUI; instruction_pc = 64'h4004;
        tick;
        tests++;
        if ({output_valid, rd, alu_op, alu_src_imm, reg_write, imm}
            !== {1'b1, 5'd4, 4'd10, 1'b1, 1'b1, 64'hFFFF_FFFF_8000_0000}) begin
            fails++;
            $display("FAIL lui: v=%b rd=%0d op=%0d src=%b rw=%b imm=%h",
                     output_valid, rd, alu_op, alu_src_imm, reg_write, imm);
        end
        instruction = I_SRAI; instruction_pc = 64'h4008;
        tick;
        tests++;
        if ({output_valid, alu_op, illegal, is_word, imm} !== {1'b1, 4'd7, 1'b0, 1'b0, 64'h43F}) begin
            fails++;
            $display("FAIL srai: v=%b op=%0d ill=%b w=%b imm=%h", output_valid, alu_op, illegal, is_word, imm);
        end
        input_valid = 1'b0;
    endtask

    task automatic test_stall;
        instruction = I_ADDI5; instruction_pc = 64'h5000; input_valid = 1'b1;
        tick;
        stall_in = 1'b1; instruction = I_ORI; instruction_pc = 64'h5004;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (stall_out !== 1'b1) begin fails++; $display("FAIL stall_out_%0d: got %b need 1", i, stall_out); end
            tick;
            tests++;
            if ({output_valid, rd, imm, out_pc} !== {1'b1, 5'd1, 64'd5, 64'h5000}) begin
                fails++;
                $display("FAIL stall_hold_%0d: v=%b rd=%0d imm=%h pc=%h need 1/1/5/5000",
                         i, output_valid, rd, imm, out_pc);
            end
        end
        stall_in = 1'b0;
        tick;
        tests++;
        if ({output_valid, rd, imm, alu_op, out_pc} !== {1'b1, 5'd2, 64'd3, 4'd8, 64'h5004}) begin
            fails++;
            $display("FAIL stall_release: v=%b rd=%0d imm=%h op=%0d pc=%h", output_valid, rd, imm, alu_op, out_pc);
        end
    endtask

    task automatic test_flush_during_stall;
        stall_in = 1'b1; branch_reset_in = 1'b1;
        tick;
        tests++;
        if ({output_valid, branch_reset_out} !== 2'b01) begin
            fails++; $display("FAIL flush_stall: v=%b bro=%b need 0/1", output_valid, branch_reset_out);
        end
        branch_reset_in = 1'b0;
        tick;
        tests++;
        if ({output_valid, branch_reset_out} !== 2'b00) begin
            fails++; $display("FAIL flush_pulse: v=%b bro=%b need 0/0", output_valid, branch_reset_out);
        end
        stall_in = 1'b0; input_valid = 1'b0;
        tick;
    endtask

    task automatic test_flush_vs_load_use;
        instruction = I_LD; instruction_pc = 64'h6000; input_valid = 1'b1;
        tick;
        instruction = I_ADD; instruction_pc = 64'h6004; branch_reset_in = 1'b1;
        #1;
        tests++;
        if (stall_out !== 1'b1) begin fails++; $display("FAIL flush_lu_stall: got %b need 1", stall_out); end
        tick;
        tests++;
        if ({output_valid, branch_reset_out} !== 2'b01) begin
            fails++; $display("FAIL flush_lu_out: v=%b bro=%b need 0/1", output_valid, branch_reset_out);
        end
        branch_reset_in = 1'b0;
        tick;
        tests++;
        if ({output_valid, rd, out_pc} !== {1'b1, 5'd7, 64'h6004}) begin
            fails++; $display("FAIL flush_lu_next: v=%b rd=%0d pc=%h need 1/7/6004", output_valid, rd, out_pc);
        end
        input_valid = 1'b0;
    endtask

    task automatic test_illegal;
        instruction = I_BADOPC; instruction_pc = 64'h7000; input_valid = 1'b1;
        tick;
        tests++;
        if ({output_valid, illegal, reg_write, mem_write, mem_read} !== 5'b11000) begin
            fails++;
            $display("FAIL ill_opcode: v=%b ill=%b rw=%b mw=%b mr=%b need 1/1/0/0/0",
                     output_valid, illegal, reg_write, mem_write, mem_read);
        end
        instruction = I_MUL; instruction_pc = 64'h7004;
        tick;
        tests++;
        if ({output_valid, illegal, reg_write, mem_write} !== 4'b1100) begin
            fails++;
            $display("FAIL ill_funct7: v=%b ill=%b rw=%b mw=%b need 1/1/0/0",
                     output_valid, illegal, reg_write, mem_write);
        end
        input_valid = 1'b0;
    endtask

    task automatic test_reset_midstream;
        instruction = I_LD; instruction_pc = 64'h8000; input_valid = 1'b1;
        tick;
        instruction = I_ADD; instruction_pc = 64'h8004; rst = 1'b1;
        tick;
        tests++;
        if ({output_valid, mem_read, rd, stall_out} !== 8'd0) begin
            fails++;
            $display("FAIL mid_reset: v=%b mr=%b rd=%0d stall=%b need 0",
                     output_valid, mem_read, rd, stall_out);
        end
        rst = 1'b0;
        tick;
        tests++;
        if ({output_valid, rd, out_pc} !== {1'b1, 5'd7, 64'h8004}) begin
            fails++; $display("FAIL post_reset: v=%b rd=%0d pc=%h need 1/7/8004", output_valid, rd, out_pc);
        end
        input_valid = 1'b0;
    endtask

    initial begin
        test_reset;
        test_addi;
        test_load_use;
        test_branch;
        test_back_to_back;
        test_stall;
        test_flush_during_stall;
        test_flush_vs_load_use;
        test_illegal;
        test_reset_midstream;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/instruction_decode.md
# instruction_decode

Second pipeline stage of the RV64I core. It sits directly downstream of instruction fetch and consumes its `output_valid` / `instruction` / `instruction_pc` triple. It performs the register-file read and decodes the instruction into control fields and a sign-extended 64-bit immediate. The results are held in a pipeline register for execute, and the stage inserts a bubble on load-use hazards and on branch flushes.

## Interface
Parameters:
- None. XLEN is fixed at 64 via `double_word` (logic [63:0]).

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `input_valid` in 1: fetch output valid.
- `instruction` in 32: raw instruction from fetch.
- `instruction_pc` in 64: PC of `instruction`.
- `rs1_addr`, `rs2_addr` out 5: combinational register-file read addresses, `instruction[19:15]` and `instruction[24:20]`.
- `rs1_data`, `rs2_data` in 64: same-cycle register-file read data. The register file is write-first, so no WB bypass is needed here.
- `stall_in` in 1: downstream stall.
- `stall_out` out 1: stall to fetch; equals `stall_in | load_use`.
- `branch_reset_in` in 1: flush request from execute.
- `branch_reset_out` out 1: `branch_reset_in` delayed one cycle.
- `output_valid` out 1: decoded bundle valid.
- `out_pc` out 64: PC of the decoded instruction.
- `rd` out 5: destination register.
- `rs1_val`, `rs2_val` out 64: operand values.
- `imm` out 64: sign-extended immediate.
- `alu_op` out 4: ALU operation.
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB.
- `alu_src_imm` out 1: ALU B operand is `imm`.
- `is_word` out 1: *W op; execute sign-extends result bit 31.
- `mem_read`, `mem_write` out 1: load / store.
- `mem_size` out 2: funct3[1:0] of the load/store.
- `mem_unsigned` out 1: funct3[2] of the load.
- `reg_write` out 1: instruction writes `rd`.
- `is_branch`, `is_jal`, `is_jalr`, `is_auipc` out 1: control-flow and AUIPC flags.
- `branch_funct3` out 3: branch condition.
- `illegal` out 1: undecodable instruction.

## Operation
Decode is combinational, on the opcode `instruction[6:0]`:
- **LUI (0110111):** U-imm, `alu_op`=PASSB, `alu_src_imm`, `reg_write`.
- **AUIPC (0010111):** U-imm, `is_auipc`, `reg_write`.
- **JAL (1101111):** J-imm, `is_jal`, `reg_write`.
- **JALR (1100111, funct3=0):** I-imm, `is_jalr`, `reg_write`.
- **BRANCH (1100011):**
  - B-imm, `is_branch`, `alu_op`=SUB.
  - funct3 ∈ {0,1,4,5,6,7} is legal.
- **LOAD (0000011):**
  - I-imm, ADD, `mem_read`, `reg_write`.
  - funct3 ∈ {0..6} is legal.
- **STORE (0100011):**
  - S-imm, ADD, `mem_write`.
  - funct3 ∈ {0..3} is legal.
- **OP-IMM (0010011) / OP-IMM-32 (0011011):**
  - I-imm, `alu_src_imm`, `reg_write`.
  - SRAI/SRAIW are selected by `instruction[30]`.
  - Shamt is 6 bits for OP-IMM and 5 bits for the W form.
  - For OP-IMM-32, `is_word`=1.
- **OP (0110011) / OP-32 (0111011):**
  - Uses `rs2_val`, `reg_write`.
  - funct7 must be 0000000 or 0100000 (the latter only for SUB/SRA).
- **Anything else:** `illegal`=1 with `reg_write`, `mem_read` and `mem_write` forced 0.

Immediate and register rules:
- Immediates are sign-extended from `instruction[31]` to 64 bits.
- The U-imm is `{inst[31:12], 12'b0}`, sign-extended.
- `rd`=0 forces `reg_write`=0.
- A source address of 0 yields a 0 value regardless of `rs*_data`.

`load_use` hazard:
- Condition: `output_valid` & `mem_read` & (`rd`≠0) & `input_valid` & (`rd`==rs1 used, or `rd`==rs2 used).
- rs2 counts as used only for BRANCH/STORE/OP/OP-32.
- rs1 counts as used for everything except LUI/AUIPC/JAL.

Pipeline register update, priority highest first:
1. `rst`: all outputs 0.
2. `branch_reset_in`: `output_valid`<=0; applies even while `stall_in` is asserted.
3. `stall_in`: all outputs hold.
4. `load_use`: `output_valid`<=0 (bubble); the other fields are don't-care.
5. Otherwise: latch the decode, with `output_valid`<=`input_valid`.

Other rules:
- `branch_reset_out` <= `branch_reset_in` every non-reset cycle.
- `stall_out` is purely combinational.

## Timing
- Latency: 1 cycle from `input_valid`/`instruction` to `output_valid`/bundle.
- Throughput: 1 instruction/cycle absent stalls.
- Reset values: every registered output is 0, including `output_valid` and `branch_reset_out`.
- `load_use` asserts `stall_out` for exactly 1 cycle. Fetch holds the instruction, which issues on the next cycle.
- `stall_in` asserted N cycles: outputs are frozen for N cycles, and `stall_out`=1 for those cycles.
- Simultaneous `branch_reset_in` and `load_use`: flush wins. `output_valid`=0, and `stall_out` still reflects `load_use` that cycle.
- Reset asserted mid-stream: outputs are 0 on the next edge, and there is no residual hazard.

## Test plan
- **ADDI x5,x0,-1** (0xFFF00293), valid, no stall:
  - Next cycle: `output_valid`=1, `rd`=5, `imm`=0xFFFFFFFFFFFFFFFF, `alu_op`=ADD.
  - Also `alu_src_imm`=1, `reg_write`=1, `rs1_val`=0.
- **LD x6,8(x1)** followed by **ADD x7,x6,x2**:
  - `stall_out`=1 for one cycle, and the bubble gives `output_valid`=0.
  - The ADD then appears with `rs1_val`=`rs1_data`.
- **BEQ with negative offset** (0xFE000EE3):
  - `is_branch`=1, `imm`=-4 sign-extended, `branch_funct3`=0, `reg_write`=0.
- **stall_in held 3 cycles with a new instruction presented:**
  - Outputs are unchanged for 3 cycles, then the new instruction latches.
- **branch_reset_in pulse while `stall_in`=1:**
  - Next cycle `output_valid`=0 and `branch_reset_out`=1 (one cycle).
- **Opcode 0x7F, and OP with funct7=0000001:**
  - `illegal`=1, `reg_write`=0, `mem_write`=0, `output_valid`=1.
